main_mem: RTL and testbench

//   Word-organised main memory for the MIPS processor, mapped at 0x8002_0000.

---
 rtl/main_mem_pkg.sv | 27 ++
 rtl/main_mem_burst_ctrl.sv | 86 ++++++++
 rtl/main_mem.sv | 62 ++++++
 tb/tb_main_mem.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared definitions for the main memory block:
// access-size encodings, burst length decode and the default memory map.
package main_mem_pkg;

    typedef enum logic [1:0] {
        ACC_1W  = 2'b00,
        ACC_4W  = 2'b01,
        ACC_8W  = 2'b10,
        ACC_16W = 2'b11
    } acc_size_t;

    localparam logic [0:31] START_ADDRESS = 32'h8002_0000;
    localparam int          DEPTH_WORDS   = 262144;

    function automatic logic [0:4] beats(input logic [1:0] acc_size);
        logic [0:4] n;
        unique case (acc_size_t'(acc_size))
            ACC_1W:  n = 5'd1;
            ACC_4W:  n = 5'd4;
            ACC_8W:  n = 5'd8;
            ACC_16W: n = 5'd16;
            default: n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/main_mem_burst_ctrl.sv
// Burst sequencer: latches the request, counts beats and produces the
// address and direction of the beat active in the current cycle.
module main_mem_burst_ctrl
    import main_mem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [0:31] addr,
    input  logic        wren,
    input  logic [1:0]  acc_size,
    output logic        busy,
    output logic        beat_active,
    output logic        beat_wren,
    output logic [0:32] beat_addr
);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t      state, state_n;
    logic [0:31] base_q, base_n;
    logic        wren_q, wren_n;
    logic [0:3]  cnt_q, cnt_n;
    logic [0:3]  last_q, last_n;
    logic [0:4]  n_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            base_q <= '0;
            wren_q <= 1'b0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            state  <= state_n;
            base_q <= base_n;
            wren_q <= wren_n;
            cnt_q  <= cnt_n;
            last_q <= last_n;
        end
    end

    assign n_req = beats(acc_size) - 5'd1;

    always_comb begin
        state_n = state;
        base_n  = base_q;
        wren_n  = wren_q;
        cnt_n   = cnt_q;
        last_n  = last_q;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    base_n = addr & 32'hFFFF_FFFC;
                    wren_n = wren;
                    last_n = n_req[1:4];
                    if (n_req != 5'd0) begin
                        state_n = ST_BURST;
                        cnt_n   = 4'd1;
                    end
                end
            end
            ST_BURST: begin
                if (cnt_q == last_q) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // 33-bit beat address so bursts past 0xFFFF_FFFC never wrap into range
    always_comb begin
        busy        = (state == ST_BURST);
        beat_active = busy | enable;
        beat_wren   = busy ? wren_q : wren;
        if (busy)
            beat_addr = {1'b0, base_q} + {27'd0, cnt_q, 2'b00};
        else
            beat_addr = {1'b0, addr & 32'hFFFF_FFFC};
    end

endmodule

// File: rtl/main_mem.sv
// Word-organised main memory: combinational reads, synchronous writes,
// single-word and 4/8/16-word bursts.
module main_mem #(
    parameter logic [0:31] START_ADDRESS = main_mem_pkg::START_ADDRESS,
    parameter int          DEPTH_WORDS   = main_mem_pkg::DEPTH_WORDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:31] addr,
    input  logic [0:31] data_in,
    output logic [0:31] data_out,
    input  logic [1:0]  acc_size,
    input  logic        wren,
    output logic        busy,
    input  logic        enable
);

    localparam int IW = $clog2(DEPTH_WORDS);

    logic        beat_active;
    logic        beat_wren;
    logic [0:32] beat_addr;
    logic [0:32] rel;
    logic [0:32] word;
    logic        in_range;
    logic [0:IW-1] idx;

    logic [0:31] mem [DEPTH_WORDS];

    main_mem_burst_ctrl u_ctrl (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .addr        (addr),
        .wren        (wren),
        .acc_size    (acc_size),
        .busy        (busy),
        .beat_active (beat_active),
        .beat_wren   (beat_wren),
        .beat_addr   (beat_addr)
    );

    always_comb begin
        rel      = beat_addr - {1'b0, START_ADDRESS};
        word     = rel >> 2;
        in_range = (beat_addr >= {1'b0, START_ADDRESS})
                 && (word < 33'(DEPTH_WORDS));
        idx      = word[33-IW:32];
    end

    always_ff @(posedge clock) begin
        if (!reset && beat_active && beat_wren && in_range)
            mem[idx] <= data_in;
    end

    always_comb begin
        data_out = '0;
        if (beat_active && !beat_wren && in_range)
            data_out = mem[idx];
    end

endmodule

// File: tb/tb_main_mem.sv
// Directed self-checking bench for main_mem.
module tb_main_mem;

    logic        clock;
    logic        reset;
    logic [0:31] addr;
    logic [0:31] data_in;
    logic [0:31] data_out;
    logic [1:0]  acc_size;
    logic        wren;
    logic        busy;
    logic        enable;

    int checks = 0;
    int errors = 0;
    int n;

    main_mem dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .acc_size (acc_size),
        .wren     (wren),
        .busy     (busy),
        .enable   (enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic w,
                       input logic [1:0] sz, input logic [31:0] d);
        enable   = 1'b1;
        addr     = a;
        wren     = w;
        acc_size = sz;
        data_in  = d;
    endtask

    task automatic idle();
        enable   = 1'b0;
        wren     = 1'b0;
        acc_size = 2'b00;
    endtask

    task automatic rd1(input string tag, input logic [31:0] a,
                       input logic [31:0] exp);
        req(a, 1'b0, 2'b00, 32'h0);
        #1;
        check(tag, data_out, exp);
        tick();
        idle();
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        req(a, 1'b1, 2'b00, d);
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        addr    = '0;
        data_in = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_dout", data_out, 32'd0);

        // 1: single write then 4-word read
        req(32'h8002_0000, 1'b1, 2'b00, 32'h55cc_55cc);
        #1;
        check("t1_wr_dout", data_out, 32'd0);
        check("t1_wr_busy", {31'd0, busy}, 32'd0);
        tick();
        req(32'h8002_0000, 1'b0, 2'b01, 32'h0);
        #1;
        check("t1_rd_dout", data_out, 32'h55cc_55cc);
        tick();
        idle();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!busy) break;
            n++;
            tick();
        end
        check("t1_busy_len", n, 3);

        // 2: 4-word write burst, then read it back
        req(32'h8002_0010, 1'b1, 2'b01, 32'd1);
        tick();
        idle();
        for (int k = 1; k < 4; k++) begin
            data_in = k + 1;
            #1;
            check("t2_wr_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        #1;
        check("t2_wr_done", {31'd0, busy}, 32'd0);
        req(32'h8002_0010, 1'b0, 2'b01, 32'h0);
        #1;
        check("t2_rd0", data_out, 32'd1);
        tick();
        idle();
        for (int k = 1; k < 4; k++) begin
            #1;
            check("t2_rd_beat", data_out, k + 1);
            tick();
        end

        // 3: 16-word read, inputs scrambled mid-burst
        req(32'h8002_0000, 1'b0, 2'b11, 32'h0);
        #1;
        check("t3_rd0", data_out, 32'h55cc_55cc);
        tick();
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            addr    = $urandom;
            wren    = i[0];
            data_in = 32'hdead_beef;
            #1;
            if (!busy) break;
            n++;
            if (i == 4) check("t3_beat4", data_out, 32'd1);
            if (i == 7) check("t3_beat7", data_out, 32'd4);
            tick();
        end
        idle();
        check("t3_busy_len", n, 15);
        rd1("t3_intact", 32'h8002_0010, 32'd1);

        // 4: out-of-range accesses and the last valid word
        wr1(32'h8012_0000, 32'h1234_5678);
        rd1("t4_above", 32'h8012_0000, 32'd0);
        rd1("t4_below", 32'h7fff_fffc, 32'd0);
        wr1(32'h8011_fffc, 32'hcafe_f00d);
        rd1("t4_top", 32'h8011_fffc, 32'hcafe_f00d);

        // 5: reset during beat 2 of an 8-word write burst
        req(32'h8002_0040, 1'b1, 2'b10, 32'ha0);
        tick();
        idle();
        data_in = 32'ha1;
        tick();
        data_in = 32'ha2;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        rd1("t5_w0", 32'h8002_0040, 32'ha0);
        rd1("t5_w1", 32'h8002_0044, 32'ha1);
        #1;
        check("t5_after", {31'd0, busy}, 32'd0);

        // 6: enable low blocks writes and forces data_out to zero
        wr1(32'h8002_0008, 32'h0bad_f00d);
        enable  = 1'b0;
        wren    = 1'b1;
        addr    = 32'h8002_0008;
        data_in = 32'hffff_ffff;
        #1;
        check("t6_dout", data_out, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        tick();
        idle();
        rd1("t6_kept", 32'h8002_0008, 32'h0bad_f00d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
